// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt capture stage.
// No logic; consumed by irq_capture and sync_edge.
// No handshakes of its own.
package irq_pkg;

  localparam int N = 8;
  localparam int IDX_W = 3;
  localparam logic [N-1:0] MASK_RST = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser per line plus a history flop for rising-edge detect.
// Latency: rise pulses one cycle, two edges after the input is first sampled high.
// No backpressure; a held level produces a single rise pulse.
module sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s3;

  // Metastability chain followed by a history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/irq_capture.sv
// Captures async request edges into sticky pending bits, masks them for the external encoder,
// and presents one interrupt at a time to the CPU. Latency: 4 edges from sampled input to irq_req.
// Backpressure: the CPU holds off further requests until it acks; new edges keep accumulating.
module irq_capture
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     irq_in,
  input  logic             mask_we,
  input  logic [N-1:0]     mask_wdata,
  output logic [N-1:0]     mask,
  output logic [N-1:0]     irq_vec,
  input  logic [IDX_W-1:0] enc_out,
  input  logic             enc_valid,
  output logic             irq_req,
  output logic [IDX_W-1:0] irq_id,
  input  logic             irq_ack
);

  logic [N-1:0]     rise;
  logic [N-1:0]     pending;
  logic [N-1:0]     clr;
  state_t           state;
  state_t           state_nxt;
  logic             req_nxt;
  logic [IDX_W-1:0] id_nxt;

  sync_edge #(.W(N)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (irq_in),
    .rise (rise)
  );

  // Serviced bit is cleared on ack; a same-cycle edge re-sets it (set wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
    end
  end

  // Mask register; masked lines still pend, they are only hidden from the encoder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= MASK_RST;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  assign irq_vec = pending & mask;

  // Handshake state and the registered outputs presented to the CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      state   <= state_nxt;
      irq_req <= req_nxt;
      irq_id  <= id_nxt;
    end
  end

  // Next-state logic; enc_out is only looked at when enc_valid says it is meaningful.
  always_comb begin
    state_nxt = state;
    req_nxt   = irq_req;
    id_nxt    = irq_id;
    clr       = '0;
    case (state)
      IDLE: begin
        if (enc_valid) begin
          id_nxt    = enc_out;
          req_nxt   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (irq_ack) begin
          clr[irq_id] = 1'b1;
          req_nxt     = 1'b0;
          state_nxt   = SETTLE;
        end
      end
      SETTLE: begin
        // One idle cycle so the encoder output reflects the cleared bit.
        state_nxt = IDLE;
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/irq_capture.md
# irq_capture

Interrupt capture and handshake stage that sits directly upstream of the 8:3 priority encoder. It synchronises eight asynchronous request lines, edge-detects them into a sticky pending register, masks them, and drives the masked vector into the encoder. It then consumes the encoder's index/valid outputs, presents one interrupt at a time to the CPU over a req/ack handshake, and clears the serviced pending bit on acknowledge.

## Interface
- `N`, 8: number of request lines. Fixed at 8 to match the encoder.
- `IDX_W`, 3: index width, equal to log2(N).
- `MASK_RST`, 8'hFF: reset value of the mask register.

- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `irq_in`  in  8  raw asynchronous request lines, level-high
- `mask_we`  in  1  mask write strobe
- `mask_wdata`  in  8  new mask value; bit=1 enables that line
- `mask`  out  8  current mask register
- `irq_vec`  out  8  `pending & mask`, combinational from registers; drives the encoder `in`
- `enc_out`  in  3  encoder index output
- `enc_valid`  in  1  encoder valid output
- `irq_req`  out  1  interrupt request to the CPU
- `irq_id`  out  3  index of the interrupt being presented; stable while `irq_req` is high
- `irq_ack`  in  1  CPU acknowledge, single-cycle strobe

## Operation
- Synchroniser: two flops per line (`s1`, `s2`) plus a history flop `s3`. A rising edge is detected as `s2 & ~s3`.
- Pending register:
  - Bit set on a detected rising edge, regardless of mask.
  - Bit cleared only by an ack of that index.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays pending.
- Mask register: when `mask_we` is high, `mask` takes `mask_wdata` at the next edge. Masked lines still accumulate pending bits; they are hidden only from `irq_vec`.
- FSM, 2-bit state:
  - IDLE: if `enc_valid`, latch `irq_id <= enc_out`, drive `irq_req <= 1`, go to WAIT.
  - WAIT: hold `irq_id` and `irq_req`. On `irq_ack`: clear `pending[irq_id]`, drive `irq_req <= 0`, go to SETTLE.
  - SETTLE: one cycle so the encoder sees the cleared vector, then go to IDLE.
- `irq_ack` is ignored in IDLE and SETTLE.
- A mask change during WAIT does not alter `irq_id` or `irq_req`; the ack still clears the latched index.
- Encoder priority is highest index first. The block does not re-prioritise: a higher-priority edge arriving during WAIT is served after the current ack.
- Reset values: `s1`/`s2`/`s3`/`pending` = 0, `mask` = `MASK_RST`, `irq_req` = 0, `irq_id` = 0, state = IDLE.
- `irq_vec` = 0 out of reset. With `pending` = 0 the encoder's `enc_out` is X, so the FSM must never sample `enc_out` unless `enc_valid` = 1.
- Reset mid-handshake: everything returns to reset values immediately, pending requests are lost, and `irq_req` drops asynchronously.

## Timing
- `irq_in[k]` first sampled high at edge E1. Then:
  - `s2` = 1 after E2.
  - `pending[k]` = 1 after E3, and `irq_vec` updates in the same cycle.
  - `irq_req` = 1 and `irq_id` valid after E4.
- This gives a latency of 4 edges from the sampled input to `irq_req`.
- `irq_ack` sampled high at edge Ea:
  - After Ea: `irq_req` = 0 and the pending bit is cleared.
  - After Ea+1: state is IDLE.
  - After Ea+2: earliest next `irq_req` assertion.
- The input must fall and rise again to re-pend. A level held high produces exactly one pending set.
- A mask write at edge Em affects `irq_vec` from the cycle after Em.

## Structure
- Shared package `irq_pkg`: `N`, `IDX_W`, the state enum (IDLE, WAIT, SETTLE) and the `MASK_RST` default.
- One natural sub-module, `sync_edge`: a 2-flop synchroniser plus rising-edge detector, instantiated per line or vectorised over 8 bits.
- The priority encoder stays external and is instantiated next to this block at the top level.

## Test plan
- Reset default mask: after reset, pulse `irq_in` = 8'h20 → `irq_req` rises 4 edges later with `irq_id` = 5. Ack → `irq_req` falls next edge and `irq_vec` = 0.
- Priority: `irq_in` = 8'h81 in the same cycle → `irq_id` = 7 first. Ack, then 2 edges later `irq_id` = 0. Ack → idle with `irq_vec` = 0.
- Masking: write mask 8'hFE, pulse `irq_in[0]` → no `irq_req` and `pending` = 8'h01. Write mask 8'hFF → `irq_req` with `irq_id` = 0 two edges after the write.
- Set-wins collision: drive a new `irq_in[3]` edge so its pending set lands on the same edge as the ack of `irq_id` = 3 → `pending[3]` stays 1 and `irq_req` re-asserts with `irq_id` = 3 after SETTLE.
- Handshake corners: ack in IDLE does nothing. A level held high on `irq_in[2]` across an ack → only one service.
- Reset mid-WAIT: with `irq_req` = 1, assert `rst` between edges → `irq_req` drops immediately. After release: `pending` = 0 and `mask` = 8'hFF.
